exe_div_unit: RTL and testbench

- Iterative radix-2 restoring divider in the EXE stage. Executes DIV and DIVU.
- While a divide is in progress it raises stallreq_div. The EXE stage ORs this into stallreq_exe at the stall control unit, which returns stall = 4'b1111 and freezes the pipeline.
- On completion it presents the remainder in HI and the quotient in LO for one cycle.

---
 rtl/exe_div_unit_if.sv | 23 ++
 rtl/exe_div_unit.sv | 109 ++++++++++
 tb/tb_exe_div_unit.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/exe_div_unit_if.sv
// Handshake and data bundle between the EXE stage and the divider.
// The EXE stage is the master; the divider is the slave.
interface exe_div_unit_if #(parameter int DATA_W = 32);
  logic                  div_start;
  logic                  div_signed;
  logic                  div_annul;
  logic [DATA_W-1:0]     div_opdata1;
  logic [DATA_W-1:0]     div_opdata2;
  logic [2*DATA_W-1:0]   div_result;
  logic                  div_ready;
  logic                  stallreq_div;
  logic                  div_busy;

  modport master (
    output div_start, div_signed, div_annul, div_opdata1, div_opdata2,
    input  div_result, div_ready, stallreq_div, div_busy
  );

  modport slave (
    input  div_start, div_signed, div_annul, div_opdata1, div_opdata2,
    output div_result, div_ready, stallreq_div, div_busy
  );
endinterface

// File: rtl/exe_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the EXE stage.
// One quotient bit per cycle; result is {remainder, quotient}, sign-corrected
// on the final iteration and held until the next completed divide.
module exe_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic           cpu_clk_50M,
  input  logic           cpu_rst,
  exe_div_unit_if.slave  div_if
);
  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE, DIVZERO, CALC, DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   dvd;      // dividend, shifts into the quotient
  logic [DATA_W-1:0]   dvs;      // divisor magnitude
  logic [DATA_W-1:0]   rem;      // partial remainder
  logic                sign_q, sign_r;

  logic [DATA_W:0]     rem_sh, diff;
  logic [DATA_W-1:0]   rem_nxt, quo_nxt;
  logic [DATA_W-1:0]   abs_op1, abs_op2;
  logic                last_iter, start_ok;

  // Magnitudes for signed divides; 0x80.. negates to itself and is used unsigned.
  assign abs_op1 = (div_if.div_signed && div_if.div_opdata1[DATA_W-1]) ? -div_if.div_opdata1 : div_if.div_opdata1;
  assign abs_op2 = (div_if.div_signed && div_if.div_opdata2[DATA_W-1]) ? -div_if.div_opdata2 : div_if.div_opdata2;
  assign start_ok  = div_if.div_start & ~div_if.div_annul;
  assign last_iter = (cnt == CNT_W'(DATA_W - 1));

  assign div_if.stallreq_div = div_if.div_start & ~div_if.div_ready & ~div_if.div_annul;
  assign div_if.div_busy     = (state != IDLE);

  // One restoring step: shift {rem, quo} left, trial-subtract, restore on borrow.
  always_comb begin
    rem_sh  = {rem, dvd[DATA_W-1]};
    diff    = rem_sh - {1'b0, dvs};
    rem_nxt = rem_sh[DATA_W-1:0];
    quo_nxt = {dvd[DATA_W-2:0], 1'b0};
    if (!diff[DATA_W]) begin
      rem_nxt = diff[DATA_W-1:0];
      quo_nxt = {dvd[DATA_W-2:0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; annul wins in every state.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_ok) state_nxt = (div_if.div_opdata2 == '0) ? DIVZERO : CALC;
      DIVZERO: state_nxt = DONE;
      CALC:    if (last_iter) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (div_if.div_annul) state_nxt = IDLE;
  end

  // Operand latch, iteration datapath and registered result/ready.
  always_ff @(posedge cpu_clk_50M or posedge cpu_rst) begin
    if (cpu_rst) begin
      cnt               <= '0;
      dvd               <= '0;
      dvs               <= '0;
      rem               <= '0;
      sign_q            <= 1'b0;
      sign_r            <= 1'b0;
      div_if.div_result <= '0;
      div_if.div_ready  <= 1'b0;
    end else begin
      div_if.div_ready <= (state_nxt == DONE);
      case (state)
        IDLE: if (start_ok) begin
          cnt <= '0;
          rem <= '0;
          if (div_if.div_opdata2 == '0) begin
            // Divide by zero reports the raw dividend as the remainder.
            dvd    <= div_if.div_opdata1;
            dvs    <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
          end else begin
            dvd    <= abs_op1;
            dvs    <= abs_op2;
            sign_q <= div_if.div_signed & (div_if.div_opdata1[DATA_W-1] ^ div_if.div_opdata2[DATA_W-1]);
            sign_r <= div_if.div_signed & div_if.div_opdata1[DATA_W-1];
          end
        end
        CALC: if (!div_if.div_annul) begin
          rem <= rem_nxt;
          dvd <= quo_nxt;
          cnt <= cnt + CNT_W'(1);
          if (last_iter)
            div_if.div_result <= {sign_r ? -rem_nxt : rem_nxt, sign_q ? -quo_nxt : quo_nxt};
        end
        DIVZERO: if (!div_if.div_annul) div_if.div_result <= {dvd, {DATA_W{1'b1}}};
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_exe_div_unit.sv
// Scoreboard bench for exe_div_unit: the driver pushes expected results,
// a negedge monitor pops and compares whenever div_ready is seen.
module tb_exe_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  exe_div_unit_if #(.DATA_W(W)) dif();
  exe_div_unit #(.DATA_W(W)) dut (.cpu_clk_50M(clk), .cpu_rst(rst), .div_if(dif));

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: plain 64-bit integer division; % keeps the dividend's sign.
  function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'b0, a});
      sb = longint'({32'b0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: every div_ready must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && dif.div_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL spurious_ready: got result %h with nothing outstanding at %0t", dif.div_result, $time);
      end else begin
        check("result", dif.div_result, exp_q.pop_front());
      end
    end
  end

  // Issue one divide, hold start until ready, release it in the DONE cycle.
  task automatic do_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int c, lat, stall_ok;
    bit seen;
    lat = (b == 0) ? 2 : W + 1;
    exp_q.push_back(exp);
    dif.div_signed  = sgn;
    dif.div_opdata1 = a;
    dif.div_opdata2 = b;
    dif.div_start   = 1'b1;
    c = 0;
    seen = 0;
    stall_ok = 1;
    while (!seen && c < 100) begin
      @(negedge clk);
      if (dif.div_ready === 1'b1) begin
        seen = 1;
        check("latency", 64'(c), 64'(lat));
        check("stall_in_done", {63'b0, dif.stallreq_div}, 64'd0);
        dif.div_start = 1'b0;
      end else begin
        if (c == 0) check("idle_at_start", {63'b0, dif.div_busy}, 64'd0);
        if (dif.stallreq_div !== 1'b1) stall_ok = 0;
        c++;
        @(posedge clk); #1;
      end
    end
    if (!seen) begin
      check("ready_timeout", 64'd0, 64'd1);
      dif.div_start = 1'b0;
      void'(exp_q.pop_back());
    end
    check("stall_while_busy", 64'(stall_ok), 64'd1);
    @(posedge clk); #1;
    check("idle_after_done", {62'b0, dif.div_busy, dif.div_ready}, 64'd0);
  endtask

  initial begin
    logic [63:0] held;
    logic [31:0] a, b;
    bit sgn;
    int mode;

    dif.div_start = 1'b0; dif.div_signed = 1'b0; dif.div_annul = 1'b0;
    dif.div_opdata1 = '0; dif.div_opdata2 = '0;

    #2;
    check("reset_result", dif.div_result, 64'd0);
    check("reset_flags", {61'b0, dif.div_ready, dif.div_busy, dif.stallreq_div}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed cases with hand-derived results.
    do_div(0, 32'd100,       32'd7,        {32'd2, 32'd14});
    do_div(1, 32'hFFFF_FFF9, 32'h2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div(1, 32'd7,         32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD});
    do_div(1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
    do_div(0, 32'hFFFF_FFFF, 32'h1,        {32'h0, 32'hFFFF_FFFF});
    do_div(0, 32'h1234,      32'h0,        {32'h1234, 32'hFFFF_FFFF});

    // Annul in cycle 10 of the op: no ready, result untouched.
    held = dif.div_result;
    dif.div_signed = 1'b0; dif.div_opdata1 = 32'd1000; dif.div_opdata2 = 32'd3;
    dif.div_start = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    dif.div_annul = 1'b1;
    #1 check("annul_stall", {63'b0, dif.stallreq_div}, 64'd0);
    @(posedge clk); #1;
    dif.div_annul = 1'b0; dif.div_start = 1'b0;
    check("annul_idle", {62'b0, dif.div_busy, dif.div_ready}, 64'd0);
    repeat (40) @(posedge clk);
    #1 check("annul_result_held", dif.div_result, held);
    do_div(0, 32'd9, 32'd3, {32'd0, 32'd3});

    // Back-to-back divides.
    do_div(0, 32'd50, 32'd5, {32'd0, 32'd10});
    do_div(0, 32'd51, 32'd5, {32'd1, 32'd10});

    // Reset pulse mid-operation.
    dif.div_signed = 1'b0; dif.div_opdata1 = 32'd77; dif.div_opdata2 = 32'd4;
    dif.div_start = 1'b1;
    repeat (15) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1 check("midreset_result", dif.div_result, 64'd0);
    check("midreset_flags", {62'b0, dif.div_ready, dif.div_busy}, 64'd0);
    dif.div_start = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    do_div(0, 32'd77, 32'd4, {32'd1, 32'd19});

    // Randomized operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      sgn  = 1'($urandom_range(0, 1));
      a    = $urandom;
      b    = $urandom;
      mode = $urandom_range(0, 7);
      case (mode)
        0: b = 32'h0;
        1: b = ($urandom_range(0, 1) != 0) ? 32'h1 : 32'hFFFF_FFFF;
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        3: b = 32'($urandom_range(1, 15));
        4: a = 32'($urandom_range(0, 20));
        default: ;
      endcase
      do_div(sgn, a, b, ref_div(sgn, a, b));
    end

    repeat (5) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
